// File: rtl/digital_pll_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : digital_pll_sequencer_if
//  Description : Configuration handshake bundle for the PLL sequencer
//                (valid/ready plus division ratio, frequency target and
//                fallback trim word).
//  Revision    : 1.0 - initial release
// ============================================================================
interface digital_pll_sequencer_if #(
    parameter int CNT_W = 12
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [4:0]       cfg_div;
    logic [CNT_W-1:0] cfg_target;
    logic [25:0]      cfg_trim;

    modport master (
        output cfg_valid, cfg_div, cfg_target, cfg_trim,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_target, cfg_trim,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/digital_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : digital_pll_sequencer
//  Description : Startup and lock-supervision controller for the digital PLL.
//                Resets and enables the PLL, waits for it to settle, measures
//                its output frequency per window from a synchronized feedback
//                counter, declares lock, retries on failure and falls back
//                to open-loop DCO mode after repeated failures.
//  Revision    : 1.0 - initial release
// ============================================================================
module digital_pll_sequencer #(
    parameter int CNT_W         = 12,
    parameter int SETTLE_CYCLES = 256,
    parameter int WINDOW_CYCLES = 64,
    parameter int TOL           = 2,
    parameter int MAX_WINDOWS   = 16,
    parameter int MAX_RETRIES   = 3
) (
    input  wire                     clock,
    input  wire                     reset,
    input  wire                     enable,
    digital_pll_sequencer_if.slave  cfg,
    input  wire  [CNT_W-1:0]        fb_count,
    output logic                    pll_resetb,
    output logic                    pll_enable,
    output logic                    pll_dco,
    output logic [4:0]              pll_div,
    output logic [25:0]             pll_ext_trim,
    output logic                    locked,
    output logic                    fail,
    output logic                    lock_lost
);

    localparam int RST_CYCLES = 4;
    localparam int SEQ_W      = $clog2(SETTLE_CYCLES + RST_CYCLES);
    localparam int WIN_W      = $clog2(WINDOW_CYCLES + 1);
    localparam int NWIN_W     = $clog2(MAX_WINDOWS + 1);
    localparam int RTY_W      = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLLRST   = 3'd1,
        S_SETTLE   = 3'd2,
        S_MEASURE  = 3'd3,
        S_LOCKED   = 3'd4,
        S_FALLBACK = 3'd5
    } state_t;

    state_t             r_state;
    logic [4:0]         r_div;
    logic [CNT_W-1:0]   r_target;
    logic [25:0]        r_trim;
    logic               r_cfg_loaded;
    logic               r_ready;
    logic [SEQ_W-1:0]   r_cnt;
    logic [WIN_W-1:0]   r_wcnt;
    logic [NWIN_W-1:0]  r_nwin;
    logic [RTY_W-1:0]   r_retry;
    logic [CNT_W-1:0]   r_base;
    logic               r_good_seen;
    logic               r_bad_seen;

    logic               w_fire;
    logic [CNT_W-1:0]   w_delta;
    logic [CNT_W-1:0]   w_err;
    logic               w_good;
    logic               w_close;
    logic               w_lock_now;
    logic               w_attempt_over;
    logic               w_retry;
    logic               w_start;
    logic [4:0]         w_new_div;

    assign cfg.cfg_ready = r_ready;
    assign w_fire        = cfg.cfg_valid & r_ready;

    // Modular subtraction makes the window delta immune to counter wrap;
    // the error magnitude is formed by ordering the operands first.
    assign w_delta = fb_count - r_base;
    assign w_err   = (w_delta >= r_target) ? (w_delta - r_target) : (r_target - w_delta);
    assign w_good  = (w_err <= CNT_W'(TOL));
    assign w_close = (r_wcnt == WIN_W'(WINDOW_CYCLES - 1));

    assign w_lock_now     = (r_state == S_MEASURE) && w_close && w_good && r_good_seen;
    assign w_attempt_over = (r_state == S_MEASURE) && w_close && !w_lock_now &&
                            (r_nwin == NWIN_W'(MAX_WINDOWS - 1));
    assign w_retry        = w_attempt_over && (r_retry < RTY_W'(MAX_RETRIES));

    // Every route into PLL reset: start from idle, reconfiguration, or retry.
    assign w_start = ((r_state == S_IDLE) && (w_fire || r_cfg_loaded)) ||
                     (((r_state == S_LOCKED) || (r_state == S_FALLBACK)) && w_fire) ||
                     w_retry;
    assign w_new_div = w_fire ? cfg.cfg_div : r_div;

    // Sequencer FSM with config capture, window measurement and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_target     <= '0;
            r_trim       <= '0;
            r_cfg_loaded <= 1'b0;
            r_ready      <= 1'b1;
            r_cnt        <= '0;
            r_wcnt       <= '0;
            r_nwin       <= '0;
            r_retry      <= '0;
            r_base       <= '0;
            r_good_seen  <= 1'b0;
            r_bad_seen   <= 1'b0;
            pll_resetb   <= 1'b0;
            pll_enable   <= 1'b0;
            pll_dco      <= 1'b0;
            pll_div      <= '0;
            pll_ext_trim <= '0;
            locked       <= 1'b0;
            fail         <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            lock_lost <= 1'b0;

            if (w_fire) begin
                r_div        <= cfg.cfg_div;
                r_target     <= cfg.cfg_target;
                r_trim       <= cfg.cfg_trim;
                r_cfg_loaded <= 1'b1;
            end

            if (!enable) begin
                r_state      <= S_IDLE;
                r_ready      <= 1'b1;
                r_retry      <= '0;
                pll_resetb   <= 1'b0;
                pll_enable   <= 1'b0;
                pll_dco      <= 1'b0;
                pll_div      <= '0;
                pll_ext_trim <= '0;
                locked       <= 1'b0;
                fail         <= 1'b0;
            end else if (w_start) begin
                r_state      <= S_PLLRST;
                r_cnt        <= '0;
                r_ready      <= 1'b0;
                r_retry      <= w_retry ? (r_retry + RTY_W'(1)) : '0;
                pll_resetb   <= 1'b0;
                pll_enable   <= 1'b1;
                pll_dco      <= 1'b0;
                pll_div      <= w_new_div;
                pll_ext_trim <= '0;
                locked       <= 1'b0;
                fail         <= 1'b0;
            end else begin
                case (r_state)
                    S_PLLRST: begin
                        if (r_cnt == SEQ_W'(RST_CYCLES - 1)) begin
                            r_state    <= S_SETTLE;
                            r_cnt      <= '0;
                            pll_resetb <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + SEQ_W'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (r_cnt == SEQ_W'(SETTLE_CYCLES - 1)) begin
                            r_state     <= S_MEASURE;
                            r_base      <= fb_count;
                            r_wcnt      <= '0;
                            r_nwin      <= '0;
                            r_good_seen <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + SEQ_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        if (w_close) begin
                            r_wcnt      <= '0;
                            r_base      <= fb_count;
                            r_nwin      <= r_nwin + NWIN_W'(1);
                            r_good_seen <= w_good;
                            if (w_lock_now) begin
                                r_state    <= S_LOCKED;
                                r_ready    <= 1'b1;
                                r_retry    <= '0;
                                r_bad_seen <= 1'b0;
                                locked     <= 1'b1;
                            end else if (w_attempt_over) begin
                                // Retries exhausted (a pending retry is taken by w_start).
                                r_state      <= S_FALLBACK;
                                r_ready      <= 1'b1;
                                pll_dco      <= 1'b1;
                                pll_ext_trim <= r_trim;
                                fail         <= 1'b1;
                            end
                        end else begin
                            r_wcnt <= r_wcnt + WIN_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (w_close) begin
                            r_wcnt <= '0;
                            r_base <= fb_count;
                            if (w_good) begin
                                r_bad_seen <= 1'b0;
                            end else if (r_bad_seen) begin
                                // Second bad window in a row: re-measure without PLL reset.
                                r_state     <= S_MEASURE;
                                r_ready     <= 1'b0;
                                r_nwin      <= '0;
                                r_good_seen <= 1'b0;
                                r_bad_seen  <= 1'b0;
                                locked      <= 1'b0;
                                lock_lost   <= 1'b1;
                            end else begin
                                r_bad_seen <= 1'b1;
                            end
                        end else begin
                            r_wcnt <= r_wcnt + WIN_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digital_pll_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digital_pll_sequencer
//  Description : Self-checking bench for digital_pll_sequencer with a
//                window-level reference model and randomized frequency data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_pll_sequencer;

    localparam int CNT_W     = 12;
    localparam int SETTLE    = 256;
    localparam int WIN       = 64;
    localparam int TOL       = 2;
    localparam int MAX_WIN   = 16;
    localparam int MAX_RETRY = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [CNT_W-1:0] fb_count;
    logic             pll_resetb, pll_enable, pll_dco;
    logic [4:0]       pll_div;
    logic [25:0]      pll_ext_trim;
    logic             locked, fail, lock_lost;

    digital_pll_sequencer_if #(.CNT_W(CNT_W)) cfg_bus ();

    digital_pll_sequencer #(
        .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .WINDOW_CYCLES(WIN),
        .TOL(TOL), .MAX_WINDOWS(MAX_WIN), .MAX_RETRIES(MAX_RETRY)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .cfg(cfg_bus),
        .fb_count(fb_count), .pll_resetb(pll_resetb), .pll_enable(pll_enable),
        .pll_dco(pll_dco), .pll_div(pll_div), .pll_ext_trim(pll_ext_trim),
        .locked(locked), .fail(fail), .lock_lost(lock_lost)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // expected outputs
    logic        exp_resetb, exp_enable, exp_dco, exp_locked, exp_fail, exp_lost, exp_ready;
    logic [4:0]  exp_div;
    logic [25:0] exp_trim;

    // window-level model of the supervisor
    bit          m_locked, m_fallback;
    int          m_good, m_bad, m_windows, m_retries, m_target;
    logic [4:0]  m_div;
    logic [25:0] m_trim;

    int seq_lock [10] = '{515, 512, 514, 510, 509, 514, 515, 600, 512, 512};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, "/resetb"},  pll_resetb,        exp_resetb);
        check_val({tag, "/enable"},  pll_enable,        exp_enable);
        check_val({tag, "/dco"},     pll_dco,           exp_dco);
        check_val({tag, "/div"},     pll_div,           exp_div);
        check_val({tag, "/trim"},    pll_ext_trim,      exp_trim);
        check_val({tag, "/locked"},  locked,            exp_locked);
        check_val({tag, "/fail"},    fail,              exp_fail);
        check_val({tag, "/lost"},    lock_lost,         exp_lost);
        check_val({tag, "/ready"},   cfg_bus.cfg_ready, exp_ready);
    endtask

    task automatic expect_idle();
        exp_resetb = 0; exp_enable = 0; exp_dco = 0; exp_div = 0; exp_trim = 0;
        exp_locked = 0; exp_fail = 0; exp_lost = 0; exp_ready = 1;
        m_locked = 0; m_fallback = 0; m_retries = 0;
    endtask

    task automatic expect_pllrst();
        exp_resetb = 0; exp_enable = 1; exp_dco = 0; exp_div = m_div; exp_trim = 0;
        exp_locked = 0; exp_fail = 0; exp_lost = 0; exp_ready = 0;
    endtask

    task automatic expect_run();
        exp_resetb = 1; exp_enable = 1; exp_dco = 0; exp_div = m_div; exp_trim = 0;
        exp_locked = m_locked; exp_fail = 0; exp_ready = m_locked;
    endtask

    task automatic expect_fallback();
        exp_resetb = 1; exp_enable = 1; exp_dco = 1; exp_div = m_div; exp_trim = m_trim;
        exp_locked = 0; exp_fail = 1; exp_lost = 0; exp_ready = 1;
    endtask

    // Model of one window close: act 0 = continue, 1 = PLL reset retry, 2 = fallback.
    task automatic close_window(input int d, output int act);
        int err;
        bit good;
        err  = d - m_target;
        if (err < 0) err = -err;
        good = (err <= TOL);
        act  = 0;
        if (m_locked) begin
            m_bad = good ? 0 : m_bad + 1;
            if (m_bad == 2) begin
                m_locked = 0; m_bad = 0; m_good = 0; m_windows = 0;
                expect_run();
                exp_lost = 1;
            end else begin
                expect_run();
            end
        end else begin
            m_windows++;
            m_good = good ? m_good + 1 : 0;
            if (m_good == 2) begin
                m_locked = 1; m_retries = 0; m_bad = 0; m_good = 0;
                expect_run();
            end else if (m_windows == MAX_WIN) begin
                if (m_retries < MAX_RETRY) begin
                    m_retries++;
                    act = 1;
                    expect_pllrst();
                end else begin
                    act = 2;
                    m_fallback = 1;
                    expect_fallback();
                end
            end else begin
                expect_run();
            end
        end
    endtask

    // Advance fb_count by exactly d over one measurement window.
    task automatic run_window(input int d, output int act);
        int inc, rem;
        inc = d / WIN;
        rem = d % WIN;
        act = 0;
        for (int k = 1; k <= WIN; k++) begin
            fb_count = fb_count + CNT_W'((k == 1) ? inc + rem : inc);
            exp_lost = 0;
            tick();
            if (k == WIN) close_window(d, act);
            check_outs("win");
        end
    endtask

    // Called on the sample right after the edge that entered PLL reset.
    // abort_at >= 0 drops enable after that many SETTLE cycles.
    task automatic start_seq(input int abort_at);
        expect_pllrst();
        check_outs("pllrst0");
        for (int i = 1; i < 4; i++) begin
            tick();
            check_outs("pllrst");
        end
        exp_resetb = 1;
        for (int i = 0; i < SETTLE; i++) begin
            if (i == abort_at) begin
                enable = 0;
                tick();
                expect_idle();
                check_outs("drop_settle");
                return;
            end
            tick();
            check_outs("settle");
        end
        tick();
        m_locked = 0; m_windows = 0; m_good = 0; m_bad = 0;
        expect_run();
        check_outs("meas_entry");
    endtask

    task automatic do_cfg(input logic [4:0] div, input int tgt, input logic [25:0] trim);
        check_val("ready_pre", cfg_bus.cfg_ready, 1'b1);
        cfg_bus.cfg_div    = div;
        cfg_bus.cfg_target = CNT_W'(tgt);
        cfg_bus.cfg_trim   = trim;
        cfg_bus.cfg_valid  = 1;
        exp_lost = 0;
        tick();
        cfg_bus.cfg_valid = 0;
        m_div = div; m_target = tgt; m_trim = trim;
        m_locked = 0; m_fallback = 0; m_retries = 0;
        if (enable) begin
            start_seq(-1);
        end else begin
            expect_idle();
            check_outs("cfg_idle");
        end
    endtask

    function automatic int pick_delta(input bit good);
        int mag;
        if (good) return m_target + int'($urandom_range(4, 0)) - 2;
        mag = 3 + int'($urandom_range(40, 0));
        return ($urandom_range(1, 0) == 1) ? m_target + mag : m_target - mag;
    endfunction

    task automatic drive_windows(input int nwin, input int pgood);
        int act;
        for (int w = 0; w < nwin; w++) begin
            if (m_fallback) break;
            run_window(pick_delta(int'($urandom_range(99, 0)) < pgood), act);
            if (act == 1) start_seq(-1);
        end
    endtask

    initial begin
        int act;
        int guard;
        reset = 1; enable = 0; fb_count = 0;
        cfg_bus.cfg_valid = 0; cfg_bus.cfg_div = 0; cfg_bus.cfg_target = 0; cfg_bus.cfg_trim = 0;
        m_div = 0; m_target = 0; m_trim = 0;
        m_good = 0; m_bad = 0; m_windows = 0;
        expect_idle();
        tick(); tick();
        check_outs("reset");
        reset = 0;

        // enable without a loaded config stays idle
        enable = 1;
        tick(); tick(); tick();
        check_outs("no_cfg");

        // nominal start: handshake in the same cycle as enable-qualified idle
        fb_count = CNT_W'($urandom);
        do_cfg(5'd8, 512, 26'($urandom));
        run_window(512, act);
        run_window(512, act);

        // boundary deltas, isolated bad window, lock loss and relock
        for (int i = 0; i < 10; i++) run_window(seq_lock[i], act);

        // reconfiguration while locked
        do_cfg(5'($urandom_range(31, 1)), int'($urandom_range(2600, 256)), 26'($urandom));
        drive_windows(2, 100);

        // wrap-safe delta with base 0xF00, config loaded while idle
        enable = 0;
        tick();
        expect_idle();
        check_outs("en_drop");
        fb_count = 12'hF00;
        do_cfg(5'($urandom_range(31, 1)), 512, 26'($urandom));
        enable = 1;
        tick();
        start_seq(-1);
        run_window(512, act);
        run_window(512, act);

        // enable drop mid-SETTLE, then restart on retained config
        enable = 0;
        tick();
        expect_idle();
        enable = 1;
        tick();
        start_seq(100);
        enable = 1;
        tick();
        start_seq(-1);
        run_window(m_target, act);
        run_window(m_target, act);

        // persistent frequency error: retries then fallback
        do_cfg(5'($urandom_range(31, 1)), 512, 26'($urandom));
        guard = 0;
        while (!m_fallback && guard < 100) begin
            run_window(448, act);
            if (act == 1) start_seq(-1);
            guard++;
        end
        check_val("fallback_reached", {31'd0, m_fallback}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs("fallback_hold");
        end
        do_cfg(5'($urandom_range(31, 1)), int'($urandom_range(2600, 256)), 26'($urandom));
        drive_windows(2, 100);

        // randomized trials
        for (int t = 0; t < 4; t++) begin
            enable = 0;
            tick();
            expect_idle();
            check_outs("trial_idle");
            fb_count = CNT_W'($urandom);
            do_cfg(5'($urandom_range(31, 1)), int'($urandom_range(2600, 256)), 26'($urandom));
            enable = 1;
            tick();
            start_seq(-1);
            drive_windows(24, 50 + int'($urandom_range(40, 0)));
        end

        // asynchronous reset mid-sequence clears config too
        #3;
        reset = 1;
        #1;
        expect_idle();
        check_outs("async_rst");
        tick();
        reset = 0;
        enable = 1;
        tick(); tick(); tick();
        check_outs("post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
